// File: rtl/config_loader_pkg.sv
// Shared types and default sizing for the configuration chain loader.
package config_loader_pkg;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cfg_word_shifter.sv
// Word register with parallel load and LSB-first shift; in CAPTURE mode
// the serial input enters at the MSB so the first bit lands in bit 0.
module cfg_word_shifter #(
    parameter int W       = 32,
    parameter bit CAPTURE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] din,
    output logic [W-1:0] data_nxt,
    output logic         lsb_nxt
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // next register value: load wins over shift, otherwise hold
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d        = data_q >> 1;
            data_d[W-1]   = CAPTURE ? sin : 1'b0;
        end else begin
            data_d = data_q;
        end
    end

    // word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign data_nxt = data_d;
    assign lsb_nxt  = data_d[0];

endmodule

// File: rtl/config_loader.sv
// Streams host words LSB-first into a serial programming chain of CHAIN_LEN bits.
// Optional readback of the chain tail is enabled with `define CFG_READBACK_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              prog_in,
    output logic              prog_en,
    input  logic              prog_out,
    output logic              busy,
    output logic              done,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);
    localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);
    localparam logic [WB_W-1:0]  WB_ZERO  = WB_W'(0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic              s_ready_q, s_ready_d;
    logic              prog_in_q, prog_in_d;
    logic              prog_en_q, prog_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_s;
    logic              shift_s;
    logic              out_lsb_nxt_s;
    logic [WORD_W-1:0] out_word_unused_s;

    cfg_word_shifter #(
        .W       (WORD_W),
        .CAPTURE (1'b0)
    ) u_out_shifter (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .load     (load_s),
        .shift    (shift_s),
        .sin      (1'b0),
        .din      (s_data),
        .data_nxt (out_word_unused_s),
        .lsb_nxt  (out_lsb_nxt_s)
    );

    // next state, counters, and outputs registered from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbit_d  = wbit_q;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = CNT_LOAD;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (s_valid) begin
                    load_s  = 1'b1;
                    wbit_d  = WB_ZERO;
                    state_d = SHIFT;
                end else begin
                    state_d = FETCH;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                wbit_d  = wbit_q + WB_ONE;
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                // chain completion takes priority over a word boundary
                if (cnt_q <= CNT_ONE) begin
                    state_d = DONE;
                end else if (wbit_q == WB_LAST) begin
                    state_d = FETCH;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d == FETCH);
        prog_en_d = (state_d == SHIFT);
        prog_in_d = (state_d == SHIFT) & out_lsb_nxt_s;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // state, counters and output registers
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            wbit_q    <= {WB_W{1'b0}};
            s_ready_q <= 1'b0;
            prog_in_q <= 1'b0;
            prog_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wbit_q    <= wbit_d;
            s_ready_q <= s_ready_d;
            prog_in_q <= prog_in_d;
            prog_en_q <= prog_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready = s_ready_q;
    assign prog_in = prog_in_q;
    assign prog_en = prog_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] cap_nxt_s;
    logic              cap_lsb_unused_s;
    logic              rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic [WB_W-1:0]   rb_pad_s;

    // every SHIFT cycle is a prog_en cycle, so the tail is sampled on the same edges
    cfg_word_shifter #(
        .W       (WORD_W),
        .CAPTURE (1'b1)
    ) u_rb_shifter (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .load     (1'b0),
        .shift    (shift_s),
        .sin      (prog_out),
        .din      ({WORD_W{1'b0}}),
        .data_nxt (cap_nxt_s),
        .lsb_nxt  (cap_lsb_unused_s)
    );

    // a partial final word sits in the upper bits; shift it down to zero-pad
    always_comb begin
        rb_valid_d = 1'b0;
        rb_data_d  = rb_data_q;
        rb_pad_s   = WB_LAST - wbit_q;
        if (shift_s && ((wbit_q == WB_LAST) || (cnt_q == CNT_ONE))) begin
            rb_valid_d = 1'b1;
            rb_data_d  = cap_nxt_s >> rb_pad_s;
        end else begin
            rb_valid_d = 1'b0;
        end
    end

    // readback output registers
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            rb_valid_q <= 1'b0;
            rb_data_q  <= {WORD_W{1'b0}};
        end else begin
            rb_valid_q <= rb_valid_d;
            rb_data_q  <= rb_data_d;
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
`else
    logic prog_out_unused_s;

    assign prog_out_unused_s = prog_out;
    assign rb_valid          = 1'b0;
    assign rb_data           = {WORD_W{1'b0}};
`endif

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 64-bit and a 40-bit chain instance, checked
// every cycle against a bit-queue model of what the chain must receive.
module tb_config_loader;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_n_v, start_v, s_valid_v, s_ready_v, prog_in_v, prog_en_v;
    logic [1:0]   prog_out_v, busy_v, done_v, rb_valid_v;
    logic [W-1:0] s_data_v [2];
    logic [W-1:0] rb_data_v [2];

    // target chain on the 64-bit instance: head at bit 63, tail at bit 0
    logic [63:0] chain = 64'h12345678_9ABCDEF0;
    always @(posedge clk) if (prog_en_v[0]) chain <= {prog_in_v[0], chain[63:1]};
    assign prog_out_v[0] = chain[0];
    assign prog_out_v[1] = 1'b0;

    config_loader #(.CHAIN_LEN(64), .WORD_W(W)) dut64 (
        .prog_clk(clk), .prog_rst_n(rst_n_v[0]), .start(start_v[0]),
        .s_valid(s_valid_v[0]), .s_data(s_data_v[0]), .s_ready(s_ready_v[0]),
        .prog_in(prog_in_v[0]), .prog_en(prog_en_v[0]), .prog_out(prog_out_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rb_valid(rb_valid_v[0]), .rb_data(rb_data_v[0])
    );

    config_loader #(.CHAIN_LEN(40), .WORD_W(W)) dut40 (
        .prog_clk(clk), .prog_rst_n(rst_n_v[1]), .start(start_v[1]),
        .s_valid(s_valid_v[1]), .s_data(s_data_v[1]), .s_ready(s_ready_v[1]),
        .prog_in(prog_in_v[1]), .prog_en(prog_en_v[1]), .prog_out(prog_out_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rb_valid(rb_valid_v[1]), .rb_data(rb_data_v[1])
    );

    int          tests = 0;
    int          fails = 0;
    int          len_of [2] = '{64, 40};
    int          rem [2], head [2], tail [2], en_cnt [2], done_cnt [2], rb_idx [2], rb_n [2];
    bit          active [2];
    bit          expq [2][128];
    logic [31:0] rb_exp [2][2];
    logic [63:0] strm [2];
    logic [31:0] rb_log [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          nb;
            logic [31:0] sd;
            logic [31:0] rbd;
            sd  = s_data_v[i];
            rbd = rb_data_v[i];
            if (!prog_en_v[i]) chk("prog_in_quiet", prog_in_v[i], 1'b0);
            if (!active[i]) begin
                chk("idle_busy", busy_v[i], 1'b0);
                chk("idle_prog_en", prog_en_v[i], 1'b0);
                chk("idle_s_ready", s_ready_v[i], 1'b0);
                chk("idle_done", done_v[i], 1'b0);
                chk("idle_rb_valid", rb_valid_v[i], 1'b0);
            end else begin
                chk("busy", busy_v[i], 1'b1);
                if (s_valid_v[i] && s_ready_v[i]) begin
                    chk("word_wanted", rem[i] > 0, 1'b1);
                    nb = (rem[i] > W) ? W : rem[i];
                    for (int k = 0; k < nb; k++) begin
                        expq[i][tail[i]] = sd[k];
                        tail[i]++;
                    end
                    rem[i] -= nb;
                end
                if (prog_en_v[i]) begin
                    chk("bit_pending", head[i] < tail[i], 1'b1);
                    if (head[i] < tail[i]) begin
                        chk("prog_in", prog_in_v[i], expq[i][head[i]]);
                        head[i]++;
                    end
                    if (en_cnt[i] < 64) strm[i][en_cnt[i]] = prog_in_v[i];
                    en_cnt[i]++;
                end
`ifdef CFG_READBACK_EN
                if (rb_valid_v[i]) begin
                    chk("rb_expected", rb_idx[i] < rb_n[i], 1'b1);
                    if (rb_idx[i] < rb_n[i]) begin
                        chk("rb_data", rbd, rb_exp[i][rb_idx[i]]);
                        if (i == 0) rb_log[rb_idx[i]] = rbd;
                        rb_idx[i]++;
                    end
                end
`endif
                if (done_v[i]) begin
                    chk("prog_en_count", en_cnt[i], len_of[i]);
                    chk("bits_unsent", tail[i] - head[i], 0);
`ifdef CFG_READBACK_EN
                    chk("rb_count", rb_idx[i], rb_n[i]);
`endif
                    done_cnt[i]++;
                    active[i] = 1'b0;
                end
            end
`ifndef CFG_READBACK_EN
            chk("rb_valid_tied", rb_valid_v[i], 1'b0);
            chk("rb_data_tied", rbd, 32'd0);
`endif
        end
    end

    task automatic do_start(input int i);
        logic [63:0] old;
        logic [63:0] sh;
        int          nb;
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        rem[i] = len_of[i]; head[i] = 0; tail[i] = 0; en_cnt[i] = 0; rb_idx[i] = 0;
        strm[i] = 64'd0;
        active[i] = 1'b1;
        // bits leaving the tail during this load are the chain's present contents
        old = (i == 0) ? chain : 64'd0;
        rb_n[i] = (len_of[i] + W - 1) / W;
        for (int k = 0; k < rb_n[i]; k++) begin
            nb = len_of[i] - W * k;
            if (nb > W) nb = W;
            sh = old >> (W * k);
            rb_exp[i][k] = (nb == W) ? sh[31:0] : (sh[31:0] & ((32'd1 << nb) - 32'd1));
        end
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [31:0] w, input int stall);
        int n;
        if (stall > 0) begin
            n = 0;
            @(negedge clk);
            while (!s_ready_v[i] && n < 200) begin @(negedge clk); n++; end
            chk("stall_reach_fetch", n < 200, 1'b1);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk("stall_hold", prog_en_v[i], 1'b0);
            end
            @(posedge clk); #1;
        end
        s_data_v[i]  = w;
        s_valid_v[i] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready_v[i] && n < 200) begin @(negedge clk); n++; end
        chk("handshake_in_time", n < 200, 1'b1);
        @(posedge clk); #1;
        s_valid_v[i] = 1'b0;
        @(negedge clk);
        chk("first_bit_en", prog_en_v[i], 1'b1);
        chk("first_bit_val", prog_in_v[i], w[0]);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int i, input bit start_in_done);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_v[i] && n < 500) begin @(negedge clk); n++; end
        chk("done_in_time", n < 500, 1'b1);
        if (start_in_done) start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input int i, input string tag);
        chk({tag, "_prog_in"}, prog_in_v[i], 1'b0);
        chk({tag, "_prog_en"}, prog_en_v[i], 1'b0);
        chk({tag, "_s_ready"}, s_ready_v[i], 1'b0);
        chk({tag, "_busy"}, busy_v[i], 1'b0);
        chk({tag, "_done"}, done_v[i], 1'b0);
        chk({tag, "_rb_valid"}, rb_valid_v[i], 1'b0);
        chk({tag, "_rb_data"}, rb_data_v[i], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n_v = 2'b00; start_v = 2'b00; s_valid_v = 2'b00;
        s_data_v[0] = 32'd0; s_data_v[1] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; done_cnt[i] = 0; en_cnt[i] = 0; rem[i] = 0; head[i] = 0; tail[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero(0, "reset64");
        chk_all_zero(1, "reset40");
        rst_n_v = 2'b11;
        @(posedge clk); #1;

        // back-to-back words; readback sees the preloaded chain
        do_start(0);
        send_word(0, 32'hA5A5A5A5, 0);
        send_word(0, 32'h0000FFFF, 0);
        wait_done(0, 1'b0);
        chk("t1_stream", strm[0], 64'h0000FFFF_A5A5A5A5);
        chk("t1_done_count", done_cnt[0], 1);
`ifdef CFG_READBACK_EN
        chk("t1_rb_word0", rb_log[0], 32'h9ABCDEF0);
        chk("t1_rb_word1", rb_log[1], 32'h12345678);
`endif

        // ten-cycle host stall between words
        do_start(0);
        send_word(0, 32'hA5A5A5A5, 0);
        send_word(0, 32'h0000FFFF, 10);
        wait_done(0, 1'b0);
        chk("t2_stream", strm[0], 64'h0000FFFF_A5A5A5A5);
        chk("t2_done_count", done_cnt[0], 2);

        // start during SHIFT and during DONE must be ignored
        do_start(0);
        send_word(0, 32'h3C3C0FF0, 0);
        pulse_start(0);
        send_word(0, 32'h80000001, 0);
        wait_done(0, 1'b1);
        chk("t3_stream", strm[0], 64'h80000001_3C3C0FF0);
        chk("t3_done_count", done_cnt[0], 3);
        chk("t3_idle_after", busy_v[0], 1'b0);

        // asynchronous reset at bit 17 aborts the load
        do_start(0);
        send_word(0, 32'hA5A5A5A5, 0);
        n = 0;
        while (en_cnt[0] < 17 && n < 200) begin @(posedge clk); n++; end
        chk("t4_reach_bit17", en_cnt[0], 17);
        #2;
        rst_n_v[0] = 1'b0;
        #1;
        chk_all_zero(0, "t4_abort");
        active[0] = 1'b0; rem[0] = 0; head[0] = 0; tail[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_v[0] = 1'b1;
        @(posedge clk); #1;
        do_start(0);
        send_word(0, 32'hA5A5A5A5, 0);
        send_word(0, 32'h0000FFFF, 0);
        wait_done(0, 1'b0);
        chk("t4_stream", strm[0], 64'h0000FFFF_A5A5A5A5);
        chk("t4_done_count", done_cnt[0], 4);

        // 40-bit chain: only the low 8 bits of the second word go out
        do_start(1);
        send_word(1, 32'hFFFFFFFF, 0);
        send_word(1, 32'hFFFFFF03, 0);
        wait_done(1, 1'b0);
        chk("t5_stream", strm[1], 64'h00000003_FFFFFFFF);
        chk("t5_tail_bits", strm[1][39:32], 8'h03);
        chk("t5_done_count", done_cnt[1], 1);
        chk("t5_other_done_count", done_cnt[0], 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
